// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and default thresholds for sync_fifo_flags
// Contents:
//   ptr_width(depth)   : pointer width, clog2 of the entry count
//   count_width(depth) : occupancy width, one bit wider than the pointer so DEPTH is representable
//   DEFAULT_AF_MARGIN  : almost_full default sits this many entries below DEPTH
//   DEFAULT_AE         : almost_empty default threshold
package fifo_pkg;

  localparam int DEFAULT_AF_MARGIN = 2;
  localparam int DEFAULT_AE        = 2;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage array, synchronous write, asynchronous read
// Ports:
//   clk     : write clock
//   wr_en   : store wr_data at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data at rd_addr
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [ptr_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [ptr_width(DEPTH)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with programmable almost flags and sticky error flags
// Build option: FIFO_FWFT_EN selects first-word-fall-through read mode (default: registered read).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   din, wr_en        : write data and write request
//   rd_en             : read request (pops the head in FWFT mode)
//   clr_err           : synchronous clear of overflow/underflow
//   dout              : read data
//   empty, full       : occupancy is 0 / DEPTH
//   almost_empty      : count <= AE_THRESH
//   almost_full       : count >= AF_THRESH
//   count             : occupancy
//   overflow          : sticky, write attempted while full
//   underflow         : sticky, read attempted while empty
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - DEFAULT_AF_MARGIN,
  parameter int AE_THRESH  = DEFAULT_AE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags decode straight from the registered count so none of them lags it.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  // Acceptance uses the pre-edge flags: a read never frees room for a
  // same-cycle write when full, and a write never feeds a same-cycle read when empty.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Pointers wrap DEPTH-1 -> 0 by natural binary overflow.
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);

      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // A new error in the same cycle as clr_err wins over the clear.
      if (wr_en && full)   overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;

      if (rd_en && empty)  underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head entry falls through combinationally; forced to 0 while empty so
  // stale array contents never show.
  assign dout = empty ? '0 : rd_data;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= rd_data;
    end
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags (vector table, corner sequences, random vs queue model)
module tb_sync_fifo_flags;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] dout;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0]    count;

  int checks   = 0;
  int failures = 0;

  sync_fifo_flags #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the externally visible registers.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout_reg = '0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout_reg = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    int  n;
    logic was_full, was_empty;
    n = q.size();
    was_full  = (n == DEPTH);
    was_empty = (n == 0);
    if (r && !was_empty) m_dout_reg = q.pop_front();
    if (w && !was_full)  q.push_back(d);
    if (w && was_full)   m_ovf = 1'b1;
    else if (c)          m_ovf = 1'b0;
    if (r && was_empty)  m_udf = 1'b1;
    else if (c)          m_udf = 1'b0;
  endtask

  function automatic logic [DW-1:0] model_dout();
`ifdef FIFO_FWFT_EN
    return (q.size() == 0) ? '0 : q[0];
`else
    return m_dout_reg;
`endif
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, "_count"}, DW'(count), DW'(n));
    chk({tag, "_empty"}, DW'(empty), DW'(n == 0));
    chk({tag, "_full"},  DW'(full),  DW'(n == DEPTH));
    chk({tag, "_ae"},    DW'(almost_empty), DW'(n <= AE));
    chk({tag, "_af"},    DW'(almost_full),  DW'(n >= AF));
    chk({tag, "_ovf"},   DW'(overflow),  DW'(m_ovf));
    chk({tag, "_udf"},   DW'(underflow), DW'(m_udf));
    chk({tag, "_dout"},  dout, model_dout());
  endtask

  task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d, input string tag);
    @(negedge clk);
    wr_en = w; rd_en = r; clr_err = c; din = d;
    @(posedge clk);
    model_edge(w, r, c, d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  typedef struct {
    logic          w, r, c;
    logic [DW-1:0] d;
    int            cnt;
    logic          emp, ful, ae, af, ovf, udf;
    logic [DW-1:0] dout;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl[NV];

  initial begin
    int k;
    int n;

    // Fill 100..115, overflow write of 999, clear, drain 16, one extra read.
    k = 0;
    for (int i = 0; i < 16; i++) begin
      n = i + 1;
      tbl[k] = '{1'b1, 1'b0, 1'b0, DW'(100 + i), n, 1'b0, n == 16, n <= 2, n >= 12, 1'b0, 1'b0,
`ifdef FIFO_FWFT_EN
                 DW'(100)};
`else
                 DW'(0)};
`endif
      k++;
    end
    tbl[k] = '{1'b1, 1'b0, 1'b0, DW'(999), 16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
`ifdef FIFO_FWFT_EN
               DW'(100)};
`else
               DW'(0)};
`endif
    k++;
    tbl[k] = '{1'b0, 1'b0, 1'b1, DW'(0), 16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
`ifdef FIFO_FWFT_EN
               DW'(100)};
`else
               DW'(0)};
`endif
    k++;
    for (int i = 0; i < 16; i++) begin
      n = 15 - i;
      tbl[k] = '{1'b0, 1'b1, 1'b0, DW'(0), n, n == 0, 1'b0, n <= 2, n >= 12, 1'b0, 1'b0,
`ifdef FIFO_FWFT_EN
                 (i < 15) ? DW'(101 + i) : DW'(0)};
`else
                 DW'(100 + i)};
`endif
      k++;
    end
    tbl[k] = '{1'b0, 1'b1, 1'b0, DW'(0), 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
`ifdef FIFO_FWFT_EN
               DW'(0)};
`else
               DW'(115)};
`endif

    // Reset state.
    model_reset();
    #12;
    check_all("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("reset_rel");

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d, "tblm");
      chk("tbl_count", DW'(count), DW'(tbl[i].cnt));
      chk("tbl_empty", DW'(empty), DW'(tbl[i].emp));
      chk("tbl_full",  DW'(full),  DW'(tbl[i].ful));
      chk("tbl_ae",    DW'(almost_empty), DW'(tbl[i].ae));
      chk("tbl_af",    DW'(almost_full),  DW'(tbl[i].af));
      chk("tbl_ovf",   DW'(overflow),  DW'(tbl[i].ovf));
      chk("tbl_udf",   DW'(underflow), DW'(tbl[i].udf));
      chk("tbl_dout",  dout, tbl[i].dout);
    end

    // Steady wr+rd at count 4 across the pointer wrap.
    step(1'b0, 1'b0, 1'b1, '0, "clr");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, DW'(300 + i), "pre4");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, DW'(200 + i), "wrrd");
      chk("wrrd_count4", DW'(count), DW'(4));
`ifndef FIFO_FWFT_EN
      chk("wrrd_dout", dout, (i < 4) ? DW'(300 + i) : DW'(200 + i - 4));
`endif
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0, "drain4");

    // wr+rd while empty: write only, underflow set.
    step(1'b1, 1'b1, 1'b0, DW'(500), "wrrd_empty");
    chk("empty_wrrd_count", DW'(count), DW'(1));
    chk("empty_wrrd_udf", DW'(underflow), DW'(1));
    step(1'b0, 1'b1, 1'b0, '0, "pop500");
    chk("pop500_count", DW'(count), DW'(0));
    // Rejected read together with clr_err: set wins.
    step(1'b0, 1'b1, 1'b1, '0, "udf_vs_clr");
    chk("udf_set_wins", DW'(underflow), DW'(1));
    step(1'b0, 0, 1'b1, '0, "udf_clr");
    chk("udf_cleared", DW'(underflow), DW'(0));

    // Asynchronous reset mid-burst at count 7.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, DW'(600 + i), "pre7");
    chk("pre7_count", DW'(count), DW'(7));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_count", DW'(count), DW'(0));
    chk("async_rst_dout", dout, DW'(0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, DW'('hA5), "wr_a5");
`ifdef FIFO_FWFT_EN
    chk("fwft_a5", dout, DW'('hA5));
`else
    step(1'b0, 1'b1, 1'b0, '0, "rd_a5");
    chk("std_a5", dout, DW'('hA5));
`endif

    // Randomised traffic in phases biased toward filling, draining and balance.
    for (int p = 0; p < 6; p++) begin
      int wp, rp;
      wp = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
      rp = (p % 3 == 0) ? 20 : (p % 3 == 1) ? 80 : 50;
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < 5, DW'($urandom), "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
